// File: rtl/mem_pkg.sv
// Shared memory-operation encodings for the decoder and the memory stage,
// plus the store lane helpers used by the load/store engine.
package mem_pkg;

  typedef enum logic [1:0] {
    NOOP = 2'b00,
    LOAD = 2'b01,
    STOR = 2'b10
  } mem_type_t;

  typedef enum logic [2:0] {
    FULL = 3'b000,
    BYTE = 3'b001,
    HALF = 3'b010
  } mem_size_t;

  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } mau_state_t;

  // Unknown size codes behave as a full word.
  function automatic mem_size_t norm_size(input logic [2:0] code);
    mem_size_t sz;
    case (code)
      3'b001:  sz = BYTE;
      3'b010:  sz = HALF;
      default: sz = FULL;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input mem_size_t sz, input logic [1:0] lo);
    return ((sz == HALF) && lo[0]) || ((sz == FULL) && (lo != 2'b00));
  endfunction

  function automatic logic [3:0] store_be(input mem_size_t sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      BYTE:    be = 4'b0001 << lo;
      HALF:    be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input mem_size_t sz, input logic [31:0] data);
    logic [31:0] d;
    case (sz)
      BYTE:    d = {4{data[7:0]}};
      HALF:    d = {2{data[15:0]}};
      default: d = data;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian load lane extraction with sign or zero extension.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic        unsigned_flag,
  output logic [31:0] data
);

  logic [31:0] shifted_s;

  // Shift the addressed byte lane down to bit 0, then extend to the access size.
  always_comb begin
    shifted_s = rdata >> {addr_lo, 3'b000};
    case (size)
      BYTE: begin
        if (unsigned_flag == EXT_ZERO) data = {24'h00_0000, shifted_s[7:0]};
        else                           data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      end
      HALF: begin
        if (unsigned_flag == EXT_ZERO) data = {16'h0000, shifted_s[15:0]};
        else                           data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      end
      default: data = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one outstanding bus access, aligned and
// extended load data for writeback, address-error exceptions on misalignment.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [1:0]        ex_mem_type,
  input  logic [2:0]        ex_mem_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_wb_dest,
  input  logic              ex_wb_en,
  input  logic              flush,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [4:0]        wb_dest,
  output logic [31:0]       wb_data,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] exc_badvaddr
);

  mau_state_t        state_r, state_nx_s;
  mem_size_t         size_s, size_r;
  logic              is_mem_s, misalign_s, needs_bus_s, can_accept_s, accept_s, done_live_s;
  logic              op_load_r, uns_r, wben_r, err_r, wbv_r, flushed_r;
  logic [1:0]        addr_lo_r;
  logic [4:0]        dest_r;
  logic              bus_req_r, bus_we_r, wb_en_r;
  logic [3:0]        bus_be_r;
  logic [ADDR_W-1:0] bus_addr_r, badvaddr_r;
  logic [31:0]       bus_wdata_r, wb_data_r, load_data_s;
  logic [4:0]        wb_dest_r;

  assign size_s       = norm_size(ex_mem_size);
  assign is_mem_s     = (ex_mem_type == LOAD) || (ex_mem_type == STOR);
  assign misalign_s   = misaligned(size_s, ex_addr[1:0]);
  assign needs_bus_s  = is_mem_s && !misalign_s;
  assign can_accept_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign accept_s     = ex_valid && can_accept_s && !flush;

  load_align u_load_align (
    .rdata         (bus_rdata),
    .addr_lo       (addr_lo_r),
    .size          (size_r),
    .unsigned_flag (uns_r),
    .data          (load_data_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state: a new operation may be taken in DONE as well as IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) state_nx_s = needs_bus_s ? ST_BUS : ST_DONE;
        else          state_nx_s = ST_IDLE;
      end
      ST_BUS: begin
        if (bus_ack) state_nx_s = ST_DONE;
        else         state_nx_s = ST_BUS;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Result pulses only live in DONE; a flush seen in BUS or in DONE itself squashes them.
  always_comb begin
    done_live_s = (state_r == ST_DONE) && !flushed_r && !flush;
    stall       = (state_r == ST_BUS) || (can_accept_s && ex_valid && needs_bus_s);
    wb_valid    = done_live_s && wbv_r;
    exc_adel    = done_live_s && err_r && op_load_r;
    exc_ades    = done_live_s && err_r && !op_load_r;
  end

  // Operation latch, bus request registers and held writeback/exception values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_load_r   <= 1'b0;
      size_r      <= FULL;
      addr_lo_r   <= 2'b00;
      uns_r       <= 1'b0;
      dest_r      <= 5'd0;
      wben_r      <= 1'b0;
      err_r       <= 1'b0;
      wbv_r       <= 1'b0;
      flushed_r   <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_be_r    <= 4'b0000;
      bus_addr_r  <= {ADDR_W{1'b0}};
      bus_wdata_r <= 32'h0000_0000;
      wb_en_r     <= 1'b0;
      wb_dest_r   <= 5'd0;
      wb_data_r   <= 32'h0000_0000;
      badvaddr_r  <= {ADDR_W{1'b0}};
    end else begin
      if (accept_s) begin
        op_load_r <= (ex_mem_type == LOAD);
        size_r    <= size_s;
        addr_lo_r <= ex_addr[1:0];
        uns_r     <= ex_unsigned;
        dest_r    <= ex_wb_dest;
        wben_r    <= ex_wb_en;
        err_r     <= is_mem_s && misalign_s;
        wbv_r     <= is_mem_s ? !misalign_s : ex_wb_en;
        flushed_r <= 1'b0;
        if (needs_bus_s) begin
          bus_req_r   <= 1'b1;
          bus_we_r    <= (ex_mem_type == STOR);
          bus_be_r    <= store_be(size_s, ex_addr[1:0]);
          bus_addr_r  <= {ex_addr[ADDR_W-1:2], 2'b00};
          bus_wdata_r <= store_data(size_s, ex_wdata);
        end
        if (is_mem_s && misalign_s) badvaddr_r <= ex_addr;
        if (!is_mem_s) begin
          wb_en_r   <= ex_wb_en;
          wb_dest_r <= ex_wb_dest;
          wb_data_r <= ex_wdata;
        end
      end else if (state_r == ST_BUS) begin
        if (flush) flushed_r <= 1'b1;
        if (bus_ack) begin
          bus_req_r <= 1'b0;
          wb_en_r   <= wben_r;
          wb_dest_r <= dest_r;
          if (op_load_r) wb_data_r <= load_data_s;
        end
      end
    end
  end

  assign bus_req      = bus_req_r;
  assign bus_we       = bus_we_r;
  assign bus_be       = bus_be_r;
  assign bus_addr     = bus_addr_r;
  assign bus_wdata    = bus_wdata_r;
  assign wb_en        = wb_en_r;
  assign wb_dest      = wb_dest_r;
  assign wb_data      = wb_data_r;
  assign exc_badvaddr = badvaddr_r;

endmodule
